// File: rtl/fft8_bf_sched_if.sv
// fft8_bf_sched_if: start/status, butterfly descriptor handshake and retire pulse of the FFT sequencer.
interface fft8_bf_sched_if;
    logic       i_start;
    logic       o_busy;
    logic       o_done;
    logic       o_bf_valid;
    logic       i_bf_ready;
    logic [2:0] o_addr_a;
    logic [2:0] o_addr_b;
    logic [1:0] o_tw_addr;
    logic [1:0] o_stage;
    logic       o_last;
    logic       i_bf_done;
    logic       o_underflow;

    modport master (
        input  i_start, i_bf_ready, i_bf_done,
        output o_busy, o_done, o_bf_valid, o_addr_a, o_addr_b, o_tw_addr, o_stage, o_last, o_underflow
    );

    modport slave (
        output i_start, i_bf_ready, i_bf_done,
        input  o_busy, o_done, o_bf_valid, o_addr_a, o_addr_b, o_tw_addr, o_stage, o_last, o_underflow
    );
endinterface

// File: rtl/fft8_bf_sched.sv
// fft8_bf_sched: stage/butterfly sequencer for an 8-point radix-2 DIF FFT, issuing in-place
// memory indices and twiddle addresses, bounding in-flight butterflies and draining between stages.
module fft8_bf_sched #(
    parameter int MAX_OUT     = 4,
    parameter int DRAIN_EXTRA = 0
) (
    input logic             i_clk,
    input logic             i_rst_n,
    fft8_bf_sched_if.master bus
);
    localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);
    localparam logic [2:0] EXTRA   = 3'(DRAIN_EXTRA);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] stage, stage_nxt, b, b_nxt, grp, j;
    logic [2:0] outstanding, out_eff, dcnt, dcnt_nxt, half, addr_a;
    logic       underflow, spurious, retire, valid, fire, issuing;

    // a retire with nothing in flight is flagged instead of wrapping the counter
    assign retire   = bus.i_bf_done && outstanding != 3'd0;
    assign spurious = bus.i_bf_done && outstanding == 3'd0;
    assign out_eff  = outstanding - {2'b0, retire};
    assign issuing  = state == ISSUE;
    assign valid    = issuing && out_eff != MAX_CNT;
    assign fire     = valid && bus.i_bf_ready;

    assign half   = 3'd4 >> stage;
    assign j      = b & 2'(half - 3'd1);
    assign grp    = b >> (2'd2 - stage);
    assign addr_a = (3'(grp) << (2'd3 - stage)) | {1'b0, j};

    assign bus.o_busy      = state != IDLE;
    assign bus.o_done      = state == DONE;
    assign bus.o_bf_valid  = valid;
    assign bus.o_addr_a    = issuing ? addr_a : 3'd0;
    assign bus.o_addr_b    = issuing ? addr_a + half : 3'd0;
    assign bus.o_tw_addr   = issuing ? j << stage : 2'd0;
    assign bus.o_stage     = state != IDLE ? stage : 2'd0;
    assign bus.o_last      = issuing && b == 2'd3;
    assign bus.o_underflow = underflow;

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        b_nxt     = b;
        dcnt_nxt  = dcnt;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = ISSUE;
                    stage_nxt = 2'd0;
                    b_nxt     = 2'd0;
                end
            end
            ISSUE: begin
                b_nxt     = fire ? b + 2'd1 : b;
                state_nxt = fire && b == 2'd3 ? DRAIN : ISSUE;
            end
            // drain ends on the cycle the last result retires, then idles EXTRA cycles
            DRAIN: begin
                if (out_eff == 3'd0) begin
                    if (dcnt == EXTRA) begin
                        dcnt_nxt  = 3'd0;
                        b_nxt     = 2'd0;
                        state_nxt = stage == 2'd2 ? DONE : ISSUE;
                        stage_nxt = stage == 2'd2 ? stage : stage + 2'd1;
                    end else begin
                        dcnt_nxt = dcnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            stage       <= 2'd0;
            b           <= 2'd0;
            outstanding <= 3'd0;
            dcnt        <= 3'd0;
            underflow   <= 1'b0;
        end else begin
            state       <= state_nxt;
            stage       <= stage_nxt;
            b           <= b_nxt;
            outstanding <= out_eff + {2'b0, fire};
            dcnt        <= dcnt_nxt;
            underflow   <= spurious || (underflow && !(state == IDLE && bus.i_start));
        end
    end
endmodule

// File: tb/tb_fft8_bf_sched.sv
// tb_fft8_bf_sched: two sequencer instances (default, and MAX_OUT=2/DRAIN_EXTRA=3) checked
// per cycle against a descriptor queue and an outstanding/drain model derived from the FFT rules.
module tb_fft8_bf_sched;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1, spur = 1'b0, rnd = 1'b0;
    int         cyc = 0, tests = 0, fails = 0;
    logic [1:0] busy_v, done_v;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d cycle %0d: got %0h, expected %0h", nm, g, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int MO  = g == 0 ? 4 : 2;
        localparam int DE  = g == 0 ? 0 : 3;
        localparam int LAT = g == 0 ? 3 : 6;

        fft8_bf_sched_if bus ();
        logic        done_drv = 1'b0;
        int          due_q[$];
        logic [10:0] exp_q[$];
        logic [10:0] desc;
        int          cnt = 0, ceff = 0, tf = 0, target = -1, h = 0, a = 0;
        logic        running = 1'b0, uf = 1'b0, ret, spu, fire, acc, exp_valid, exp_done;

        fft8_bf_sched #(.MAX_OUT(MO), .DRAIN_EXTRA(DE)) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .bus    (bus)
        );

        assign bus.i_start    = start;
        assign bus.i_bf_ready = ready;
        assign bus.i_bf_done  = done_drv | spur;
        assign busy_v[g]      = bus.o_busy;
        assign done_v[g]      = bus.o_done;
        assign desc = {bus.o_stage, bus.o_last, bus.o_tw_addr, bus.o_addr_a, bus.o_addr_b};

        // butterfly unit: retires in order, one per cycle, once due
        initial forever begin
            @(posedge clk);
            #1;
            done_drv = 1'b0;
            if (due_q.size() > 0) begin
                if (due_q[0] <= cyc) begin
                    done_drv = 1'b1;
                    void'(due_q.pop_front());
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                running = 1'b0;
                uf      = 1'b0;
                cnt     = 0;
                tf      = 0;
                target  = -1;
                due_q.delete();
                exp_q.delete();
            end else begin
                ret       = bus.i_bf_done && cnt > 0;
                spu       = bus.i_bf_done && cnt == 0;
                ceff      = cnt - int'(ret);
                fire      = bus.o_bf_valid && bus.i_bf_ready;
                exp_done  = running && tf == 12 && cyc == target;
                exp_valid = running && ((tf % 4 != 0 || tf == 0) ? ceff < MO
                                        : tf < 12 && target >= 0 && cyc >= target);
                chk("underflow", g, 32'(bus.o_underflow), 32'(uf));
                chk("busy", g, 32'(bus.o_busy), 32'(running));
                chk("done", g, 32'(bus.o_done), 32'(exp_done));
                chk("valid", g, 32'(bus.o_bf_valid), 32'(exp_valid));
                if (!running) chk("idle_desc", g, 32'(desc), 0);
                else if (bus.o_bf_valid)
                    chk("desc", g, 32'(desc), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hdead);
                if (fire) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    tf++;
                    target = -1;
                    due_q.push_back(cyc + (rnd ? int'($urandom_range(1, 8)) : LAT));
                end
                cnt = ceff + int'(fire);
                if (fire) chk("outstanding_limit", g, 32'(cnt <= MO), 1);
                if (running && tf > 0 && tf % 4 == 0 && cnt == 0 && target < 0) target = cyc + 1 + DE;
                acc = bus.i_start && !running;
                if (exp_done) running = 1'b0;
                uf = (uf && !acc) || spu;
                if (acc) begin
                    running = 1'b1;
                    tf      = 0;
                    target  = -1;
                    for (int s = 0; s < 3; s++) begin
                        for (int k = 0; k < 4; k++) begin
                            h = 4 >> s;
                            a = (k / h) * 2 * h + k % h;
                            exp_q.push_back({2'(s), k == 3, 2'((k % h) << s), 3'(a), 3'(a + h)});
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(output int s0);
        step();
        start = 1'b1;
        s0    = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int g, input int s0, input int want);
        int n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (done_v[g]) break;
            n++;
        end
        chk("done_cycle", g, n < 400 ? cyc - s0 : -1, want);
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (busy_v != 2'b00 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 0, 32'(n < lim), 1);
    endtask

    initial begin
        int s0, n;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        // nominal run: fires 1-4/8-11/15-18, done at 22 (u1: done at 52)
        pulse_start(s0);
        wait_done(0, s0, 22);
        wait_done(1, s0, 52);
        wait_idle(100);
        // retire with nothing outstanding sets the sticky flag
        step();
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (5) step();
        // backpressure at stage 1 b=2 and a start pulse while busy
        pulse_start(s0);
        while (cyc < s0 + 5) step();
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc < s0 + 10) step();
        ready = 1'b0;
        repeat (5) step();
        ready = 1'b1;
        wait_done(0, s0, 27);
        wait_idle(200);
        // reset at stage 1 b=1, then a fresh full run
        pulse_start(s0);
        while (cyc < s0 + 9) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (30) step();
        pulse_start(s0);
        wait_done(0, s0, 22);
        wait_done(1, s0, 52);
        wait_idle(100);
        // random ready and random retire latency
        rnd = 1'b1;
        repeat (6) begin
            pulse_start(s0);
            n = 0;
            while (busy_v != 2'b00 && n < 3000) begin
                ready = $urandom_range(0, 2) != 0;
                step();
                n++;
            end
            ready = 1'b1;
            chk("rand_idle", 0, 32'(n < 3000), 1);
            repeat (3) step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft8_bf_sched.md
Name: fft8_bf_sched

Overview:
- Sequencer for the 8-point radix-2 DIF floating-point FFT.
- Walks 3 stages × 4 butterflies. Per butterfly it issues the two data-memory indices and the 2-bit twiddle address that drives the twiddle ROM.
- Hands each butterfly to the butterfly unit over a valid/ready handshake.
- Tracks in-flight butterflies and drains the pipeline between stages to avoid read-after-write hazards on the in-place buffer.

Parameters:
- MAX_OUT, 4, max butterflies issued but not yet retired (1..7); issue stalls at this limit.
- DRAIN_EXTRA, 0, extra idle cycles after drain before the next stage (0..7), covering memory write latency.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_start  input  1  start one FFT; sampled only in IDLE.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the FFT completes.
- o_bf_valid  output  1  butterfly descriptor valid.
- i_bf_ready  input  1  butterfly unit accepts the descriptor.
- o_addr_a  output  3  upper-leg data index.
- o_addr_b  output  3  lower-leg data index.
- o_tw_addr  output  2  twiddle ROM address.
- o_stage  output  2  current stage 0..2.
- o_last  output  1  descriptor is the last butterfly of its stage.
- i_bf_done  input  1  one-cycle pulse: one butterfly result written back.
- o_underflow  output  1  sticky: i_bf_done seen with zero outstanding; cleared on accepted start.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) forces:
  - state=IDLE; stage=0; b=0; outstanding=0; drain counter=0.
  - All outputs 0, including o_underflow.
  - Reset mid-operation abandons the FFT with no o_done.
- States are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 → ISSUE with stage=0, b=0; o_underflow cleared.
  - i_start is ignored in every other state.
- ISSUE:
  - o_bf_valid=1 unless outstanding==MAX_OUT (after that cycle's retire is accounted for).
  - Fire = o_bf_valid & i_bf_ready.
  - o_addr_a/o_addr_b/o_tw_addr/o_stage/o_last hold stable while valid & !ready.
  - On fire: b increments. A fire with b==3 → DRAIN.
- Address generation for stage s, butterfly b:
  - half = 4>>s; j = b & (half-1); grp = b / half.
  - addr_a = grp·2·half + j; addr_b = addr_a + half; tw = j<<s.
  - Stage 0: pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
  - Stage 1: pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - Stage 2: pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - o_last = (b==3).
- Outstanding counter:
  - +1 on fire, -1 on i_bf_done.
  - Both in the same cycle → unchanged.
  - i_bf_done with count 0 → count stays 0 and o_underflow is set.
- DRAIN:
  - o_bf_valid=0.
  - Drain is complete when next-cycle outstanding==0, i.e. a retire in the same cycle counts.
  - After drain completes, wait DRAIN_EXTRA cycles.
  - Then stage<2 → stage+1, b=0, ISSUE; stage==2 → DONE.
- DONE: o_done=1 for exactly one cycle, o_busy=1, → IDLE next cycle.
- Cycle timing with ready=1, DRAIN_EXTRA=0, retire fixed at 3 cycles after fire:
  - Start sampled at cycle 0.
  - Fires at cycles 1–4, 8–11, 15–18.
  - o_done at cycle 22; IDLE at cycle 23.

Test Plan:
- Basic run: reset, pulse i_start at cycle 0, ready=1, done 3 cycles after each fire, DRAIN_EXTRA=0 → 12 fires at cycles 1–4/8–11/15–18; pair/tw sequences exactly as listed above; o_done only at cycle 22; o_underflow=0.
- Backpressure: i_bf_ready low for 5 cycles during stage 1, b=2 → descriptor stays (4,6), tw=0, o_stage=1 throughout; no skipped or duplicated butterfly; o_done delayed 5 cycles.
- MAX_OUT=2, retire latency 6 → o_bf_valid drops after 2 outstanding; resumes the cycle a retire arrives; count never exceeds 2.
- Same-cycle fire and retire → count unchanged. Retire on the last outstanding in DRAIN → next stage issues the following cycle. DRAIN_EXTRA=3 → stage gap grows by 3 cycles.
- Spurious i_bf_done in IDLE → o_underflow=1 and held; next i_start clears it; i_start pulsed while busy → no restart, o_stage sequence unaffected.
- Assert i_rst_n=0 at stage 1, b=1 → next cycle all outputs 0, state IDLE, no o_done; a fresh i_start then runs a full correct FFT.
